// File: rtl/aes128_type_pkg.sv
// Shared AES-128 datapath types and constants for the round pipeline stages.
package aes128_type_pkg;

  localparam int AES_BYTES = 16;
  localparam logic [15:0] AES_MASK_FULL = '1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FINISH
  } ark_state_t;

  // GF(2^8) addition of a key byte, or pass the data byte through untouched.
  function automatic logic [7:0] ark_byte(input logic [7:0] data,
                                          input logic [7:0] key,
                                          input logic       en);
    return data ^ (en ? key : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_add_round_key.sv
// Byte-serial AddRoundKey and AES state writeback, with single-cycle block load
// and arrival tracking that flags missing or duplicate bytes per round.
module aes128_add_round_key
  import aes128_type_pkg::*;
#(
  parameter int NUM_BYTES = AES_BYTES
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [NUM_BYTES*8-1:0]     key_i,
  input  logic                       xor_en_i,
  input  logic [7:0]                 data_i,
  input  logic [$clog2(NUM_BYTES)-1:0] addr_i,
  input  logic                       valid_i,
  input  logic                       src_done_i,
  input  logic                       load_i,
  input  logic [NUM_BYTES*8-1:0]     block_i,
  output logic [NUM_BYTES*8-1:0]     state_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o
);

  localparam int AW = $clog2(NUM_BYTES);

  ark_state_t               fsm_reg;
  logic [NUM_BYTES*8-1:0]   state_reg;
  logic [NUM_BYTES-1:0]     mask_reg;
  logic                     dup_reg;
  logic                     done_reg;
  logic                     error_reg;

  logic                     collect_wr;
  logic [NUM_BYTES-1:0]     lane_we;
  logic [NUM_BYTES*8-1:0]   lane_byte;
  logic [NUM_BYTES*8-1:0]   load_word;
  logic [NUM_BYTES-1:0]     mask_next;
  logic                     dup_next;

  assign collect_wr = valid_i && (fsm_reg == COLLECT);

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      assign lane_we[gi]           = collect_wr && (addr_i == AW'(gi));
      assign lane_byte[gi*8 +: 8]  = ark_byte(data_i, key_i[gi*8 +: 8], xor_en_i);
      assign load_word[gi*8 +: 8]  = ark_byte(block_i[gi*8 +: 8], key_i[gi*8 +: 8], xor_en_i);
    end
  endgenerate

  // Include a byte arriving alongside src_done_i before judging the round.
  assign mask_next = mask_reg | lane_we;
  assign dup_next  = dup_reg | (|(mask_reg & lane_we));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      mask_reg  <= '0;
      dup_reg   <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (start_i) begin
            mask_reg  <= '0;
            dup_reg   <= 1'b0;
            error_reg <= 1'b0;
            fsm_reg   <= COLLECT;
          end else if (load_i) begin
            state_reg <= load_word;
            error_reg <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        COLLECT: begin
          for (int i = 0; i < NUM_BYTES; i++) begin
            if (lane_we[i]) state_reg[i*8 +: 8] <= lane_byte[i*8 +: 8];
          end
          if (start_i) begin
            mask_reg <= '0;
            dup_reg  <= 1'b0;
          end else begin
            mask_reg <= mask_next;
            dup_reg  <= dup_next;
            if (src_done_i) begin
              fsm_reg   <= FINISH;
              done_reg  <= 1'b1;
              error_reg <= dup_next | ~(&mask_next);
            end
          end
        end
        FINISH:  fsm_reg <= IDLE;
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign state_o = state_reg;
  assign busy_o  = (fsm_reg == COLLECT);
  assign done_o  = done_reg;
  assign error_o = error_reg;

endmodule

// File: tb/tb_aes128_add_round_key.sv
// Randomized scoreboard bench: a byte-array reference model predicts the state
// and error flag; a monitor checks them on every done_o pulse.
module tb_aes128_add_round_key;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         start_i, xor_en_i, valid_i, src_done_i, load_i;
  logic [127:0] key_i, block_i;
  logic [7:0]   data_i;
  logic [3:0]   addr_i;
  logic [127:0] state_o;
  logic         busy_o, done_o, error_o;

  aes128_add_round_key dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .key_i(key_i),
    .xor_en_i(xor_en_i), .data_i(data_i), .addr_i(addr_i), .valid_i(valid_i),
    .src_done_i(src_done_i), .load_i(load_i), .block_i(block_i),
    .state_o(state_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [127:0] st;
    logic         err;
  } exp_t;

  exp_t     exp_q[$];
  logic [7:0] m_st[16];
  int       st_addr[$];
  logic [7:0] st_data[$];
  int       checks = 0;
  int       failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [127:0] model_word();
    logic [127:0] w;
    for (int n = 0; n < 16; n++) w[n*8 +: 8] = m_st[n];
    return w;
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding prediction.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_n_i === 1'b1 && done_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done_o=1 expected no completion");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_state", state_o, e.st);
          @(negedge clk_i);
          chk("done_error", {127'd0, error_o}, {127'd0, e.err});
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic do_load(input logic [127:0] blk, input logic [127:0] key, input logic xe);
    exp_t e;
    for (int n = 0; n < 16; n++) m_st[n] = blk[n*8 +: 8] ^ (xe ? key[n*8 +: 8] : 8'h00);
    e.st = model_word();
    e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clk_i);
    load_i = 1'b1; block_i = blk; key_i = key; xor_en_i = xe;
    @(negedge clk_i);
    load_i = 1'b0;
    drain();
  endtask

  // Sends the bytes queued in st_addr/st_data as one round.
  task automatic do_round(input logic [127:0] key, input logic xe, input bit coincident);
    exp_t e;
    bit   seen[16];
    bit   dup = 0;
    bit   miss = 0;
    int   cnt;
    for (int n = 0; n < 16; n++) seen[n] = 0;
    for (int i = 0; i < st_addr.size(); i++) begin
      if (seen[st_addr[i]]) dup = 1;
      seen[st_addr[i]] = 1;
      m_st[st_addr[i]] = st_data[i] ^ (xe ? key[st_addr[i]*8 +: 8] : 8'h00);
    end
    for (int n = 0; n < 16; n++) if (!seen[n]) miss = 1;
    e.st = model_word();
    e.err = dup | miss;
    exp_q.push_back(e);

    @(negedge clk_i);
    start_i = 1'b1; key_i = key; xor_en_i = xe;
    @(negedge clk_i);
    start_i = 1'b0;
    cnt = st_addr.size();
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk_i);
      valid_i = 1'b1;
      addr_i = 4'(st_addr[i]);
      data_i = st_data[i];
      src_done_i = (coincident && i == cnt - 1);
      @(negedge clk_i);
      valid_i = 1'b0;
      src_done_i = 1'b0;
    end
    if (!coincident || cnt == 0) begin
      src_done_i = 1'b1;
      @(negedge clk_i);
      src_done_i = 1'b0;
    end
    st_addr.delete();
    st_data.delete();
    drain();
  endtask

  initial begin
    logic [127:0] exp_w;
    int perm[16];
    rst_n_i = 1'b0; start_i = 0; xor_en_i = 0; valid_i = 0; src_done_i = 0;
    load_i = 0; key_i = '0; block_i = '0; data_i = '0; addr_i = '0;
    for (int n = 0; n < 16; n++) m_st[n] = 8'h00;
    repeat (3) @(negedge clk_i);
    chk("reset_state", state_o, 128'd0);
    chk("reset_flags", {125'd0, busy_o, done_o, error_o}, 128'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Known-answer full-block load
    do_load(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    chk("load_vector", state_o, 128'h00102030405060708090a0b0c0d0e0f0);

    // In-order round, last byte coincident with src_done_i
    for (int n = 0; n < 16; n++) begin
      st_addr.push_back(n);
      st_data.push_back(8'(n * 8'h11));
    end
    do_round({16{8'hFF}}, 1'b1, 1'b1);
    for (int n = 0; n < 16; n++) exp_w[n*8 +: 8] = ~(8'(n * 8'h11));
    chk("inorder_bytes", state_o, exp_w);

    // Reversed order, passthrough
    for (int n = 15; n >= 0; n--) begin
      st_addr.push_back(n);
      st_data.push_back(8'($urandom));
    end
    do_round({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);

    // Missing byte 7 keeps its earlier value
    for (int n = 0; n < 16; n++) begin
      if (n != 7) begin
        st_addr.push_back(n);
        st_data.push_back(8'($urandom));
      end
    end
    do_round({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    chk("error_held", {127'd0, error_o}, 128'd1);

    // start_i clears the sticky error; an empty round then flags missing bytes
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("start_clears_error", {126'd0, busy_o, error_o}, 128'd2);
    begin
      exp_t e;
      e.st = model_word();
      e.err = 1'b1;
      exp_q.push_back(e);
    end
    src_done_i = 1'b1;
    @(negedge clk_i);
    src_done_i = 1'b0;
    drain();

    // Duplicate addr 3, last write wins
    st_addr.push_back(3);
    st_data.push_back(8'hAA);
    for (int n = 0; n < 16; n++) begin
      st_addr.push_back(n);
      st_data.push_back(n == 3 ? 8'h55 : 8'($urandom));
    end
    do_round(128'd0, 1'b1, 1'b1);
    chk("dup_byte3", {120'd0, state_o[31:24]}, 128'h55);

    // Randomized loads and rounds with drops and duplicates
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      end else begin
        int drop, dupa;
        for (int n = 0; n < 16; n++) perm[n] = n;
        for (int n = 15; n > 0; n--) begin
          int j, tmp;
          j = $urandom_range(0, n);
          tmp = perm[n]; perm[n] = perm[j]; perm[j] = tmp;
        end
        drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
        dupa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
        for (int n = 0; n < 16; n++) begin
          if (perm[n] != drop) begin
            st_addr.push_back(perm[n]);
            st_data.push_back(8'($urandom));
          end
          if (perm[n] == dupa) begin
            st_addr.push_back(dupa);
            st_data.push_back(8'($urandom));
          end
        end
        do_round({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom));
      end
    end

    // Reset after 5 bytes discards the round
    @(negedge clk_i);
    start_i = 1'b1; key_i = {$urandom, $urandom, $urandom, $urandom}; xor_en_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int n = 0; n < 5; n++) begin
      valid_i = 1'b1; addr_i = 4'(n); data_i = 8'($urandom);
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int n = 0; n < 16; n++) m_st[n] = 8'h00;
    chk("midreset_state", state_o, 128'd0);
    chk("midreset_flags", {125'd0, busy_o, done_o, error_o}, 128'd0);
    valid_i = 1'b1; addr_i = 4'd9; data_i = 8'hC3; src_done_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; src_done_i = 1'b0;
    @(negedge clk_i);
    chk("idle_valid_ignored", state_o, 128'd0);
    chk("idle_no_busy", {127'd0, busy_o}, 128'd0);

    do_load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes128_add_round_key.md
Name: aes128_add_round_key

Overview:
- Byte-serial AddRoundKey and state writeback stage, directly downstream of the byte-serial mix-column stage.
- Consumes the (data, addr, valid, done) byte stream, XORs each byte with the matching round-key byte, and assembles the 128-bit AES state register.
- Also supports a single-cycle full-block load, used for the initial round and for rounds that bypass mix-column (final encrypt round, decrypt ordering).
- Tracks which bytes have arrived and flags incomplete or duplicate rounds.

Parameters:
- NUM_BYTES, 16, bytes per AES state; fixed for AES-128 (also sets the mask and address widths).

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  synchronous active-low reset
- start_i  input  1  begin a byte-serial round: clear the arrival mask, enter COLLECT
- key_i  input  128  current round key; byte n = key_i[n*8+:8]; held stable for the whole round
- xor_en_i  input  1  1: XOR the incoming byte with the key byte; 0: write the byte through unchanged
- data_i  input  8  incoming byte (from mix-column data_o)
- addr_i  input  4  byte index 0..15; index = col*4 + row
- valid_i  input  1  data_i/addr_i qualifier, single-cycle pulses
- src_done_i  input  1  source finished emitting bytes
- load_i  input  1  full-block load, accepted only in IDLE
- block_i  input  128  block for load_i
- state_o  output  128  assembled state; byte n = state_o[n*8+:8]
- busy_o  output  1  high in COLLECT
- done_o  output  1  one-cycle completion pulse
- error_o  output  1  sticky: missing or duplicate byte in the last round; cleared by start_i or load_i

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low (rst_n_i sampled on the rising edge of clk_i).
- Reset values: state register 0, mask 0, FSM IDLE, done_o 0, error_o 0, busy_o 0.
- FSM states: IDLE, COLLECT, FINISH.
- IDLE:
  - load_i: state <= block_i ^ (xor_en_i ? key_i : 0); done_o pulses on the next cycle; error_o cleared; FSM stays IDLE.
  - start_i: mask <= 0, error_o <= 0, next state COLLECT.
  - start_i and load_i together: start_i wins; load ignored.
  - valid_i in IDLE: ignored; state is unchanged.
- COLLECT:
  - On each valid_i: state[addr_i*8+:8] <= data_i ^ (xor_en_i ? key_i[addr_i*8+:8] : 0); mask[addr_i] <= 1.
  - Duplicate: valid_i with mask[addr_i] already set still writes the byte, and sets the dup flag.
  - src_done_i: next state FINISH. The mix-column stage raises its final valid and its done in the same cycle, so a valid_i coincident with src_done_i must be written and counted in the mask before the check.
  - start_i in COLLECT: restart; mask cleared, state contents kept.
- FINISH (one cycle):
  - done_o = 1.
  - error_o <= dup | (mask != all-ones).
  - Next state IDLE.
- Latency:
  - Byte write is visible on state_o the cycle after valid_i.
  - done_o rises the cycle after src_done_i.
  - done_o for load_i is one cycle after load_i.
- Arithmetic: GF(2^8) addition only (XOR); no carries. addr_i is 4 bits and always in range.
- Mid-operation reset: everything returns to reset values in the same cycle; a partial round is discarded.
- Stability: state_o changes only on accepted writes or loads; it holds stable in IDLE for the next stage to read.

Decomposition:
- aes128_type_pkg gains:
  - ark_state_t enum {IDLE, COLLECT, FINISH};
  - localparam AES_BYTES = 16;
  - localparam logic [15:0] AES_MASK_FULL = '1.
- Existing mode_t is not needed here; the caller selects xor_en_i per mode and round.
- No sub-module; the byte-lane XOR/write decode is inline (16 lanes, addressed write enable).

Test Plan:
- Full load:
  - Stimulus: load_i with block_i = 00112233445566778899aabbccddeeff, key_i = 000102030405060708090a0b0c0d0e0f, xor_en_i = 1.
  - Required: state_o = 00102030405060708090a0b0c0d0e0f0, done_o pulses next cycle, error_o = 0.
- In-order serial round:
  - Stimulus: start_i, then bytes addr 0..15 with data = addr*0x11, key all 0xFF, xor_en_i = 1; src_done_i coincident with the addr 15 valid.
  - Required: byte n = ~(n*0x11); done_o 1 cycle after src_done_i; error_o = 0.
- Permuted order, passthrough:
  - Stimulus: bytes in order col-major reversed (15..0), xor_en_i = 0.
  - Required: state_o equals the raw bytes; error_o = 0.
- Missing byte:
  - Stimulus: send 15 bytes (skip addr 7), then src_done_i.
  - Required: done_o pulses, error_o = 1, byte 7 keeps its prior value; a later start_i clears error_o.
- Duplicate byte:
  - Stimulus: addr 3 sent twice (0xAA then 0x55, key 0, xor_en_i = 1) plus all other bytes.
  - Required: byte 3 = 0x55, error_o = 1.
- Reset mid-round:
  - Stimulus: rst_n_i low after 5 bytes.
  - Required: state_o = 0, busy_o = 0, FSM IDLE; a following valid_i is ignored until start_i.
